// File: rtl/count_run_pkg.sv
// ---------------------------------------------------------------------------
// count_run_pkg
//   Shared definitions for the count-run sequencing controller.
//   - state_t  : controller state encoding (2 bits)
//   - DIR_*    : step-direction encoding of the cfg_down / latched direction bit
// ---------------------------------------------------------------------------
package count_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_run_presc.sv
// ---------------------------------------------------------------------------
// count_run_presc
//   Step prescaler for the count-run controller. Built only when
//   COUNT_RUN_PRESCALE_EN is defined.
//   Down-counter reloaded with presc on clr or on each tick, so tick fires
//   once every presc+1 cycles after clr is released.
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   clr    in   restart the prescale period (held while the controller loads)
//   presc  in   period minus one
//   tick   out  step enable, high for one cycle per period
// ---------------------------------------------------------------------------
module count_run_presc #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= presc;
        else
            cnt <= cnt - PRESC_W'(1);
    end

endmodule

// File: rtl/count_run_ctrl.sv
// ---------------------------------------------------------------------------
// count_run_ctrl
//   Sequencing controller for an up/down counter. A start pulse in IDLE
//   latches target/direction/repeat, the counter is loaded with its start
//   value, stepped one per step enable until it equals the end value, and a
//   one-cycle done is raised. With repeat latched the run reloads from the
//   latched configuration; stop aborts (highest priority).
//
// Build option
//   COUNT_RUN_PRESCALE_EN : adds cfg_presc and a prescaler so the counter
//                           steps every cfg_presc+1 cycles while running.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request a run (honoured only in IDLE, and not with stop)
//   stop        in   abort request
//   cfg_target  in   end value when counting up, start value when down
//   cfg_down    in   0: 0 -> target, 1: target -> 0
//   cfg_repeat  in   rerun automatically after each completion
//   cfg_presc   in   step period minus one (prescale build only)
//   count       out  current counter value
//   busy        out  controller not idle
//   done        out  one-cycle completion pulse (state DONE)
//   aborted     out  one-cycle pulse after a stop accepted in LOAD/RUN
// ---------------------------------------------------------------------------
module count_run_ctrl
    import count_run_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   cfg_target,
    input  logic               cfg_down,
    input  logic               cfg_repeat,
`ifdef COUNT_RUN_PRESCALE_EN
    input  logic [PRESC_W-1:0] cfg_presc,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   tgt_q;
    logic               dir_q;
    logic               rep_q;
    logic               aborted_q, aborted_d;
    logic               cfg_ld;
    logic               step;

    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   end_val;
    logic [WIDTH-1:0]   count_nxt;

    // ------------------------------------------------------------------
    // Step enable
    // ------------------------------------------------------------------
`ifdef COUNT_RUN_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc_q <= '0;
        else if (cfg_ld)
            presc_q <= cfg_presc;
    end

    // Held in clear throughout LOAD so the first step lands presc+1
    // cycles after RUN is entered, including on repeat reloads.
    count_run_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == ST_LOAD),
        .presc (presc_q),
        .tick  (step)
    );
`else
    // Prescale width has no effect in this build.
    localparam int unused_presc_w = PRESC_W;

    assign step = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign start_val = (dir_q == DIR_DOWN) ? tgt_q : '0;
    assign end_val   = (dir_q == DIR_DOWN) ? '0    : tgt_q;
    assign count_nxt = (dir_q == DIR_DOWN) ? count_q - WIDTH'(1)
                                           : count_q + WIDTH'(1);

    // ------------------------------------------------------------------
    // Configuration latch: captured only on an accepted start, so live
    // cfg_* changes during a run (or across repeats) are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q <= '0;
            dir_q <= DIR_UP;
            rep_q <= 1'b0;
        end else if (cfg_ld) begin
            tgt_q <= cfg_target;
            dir_q <= cfg_down;
            rep_q <= cfg_repeat;
        end
    end

    // ------------------------------------------------------------------
    // FSM state, counter and abort pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            aborted_q <= aborted_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state / counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        aborted_d = 1'b0;
        cfg_ld    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_LOAD;
                    cfg_ld  = 1'b1;
                end
            end

            ST_LOAD: begin
                if (stop) begin
                    // Abort before loading: count keeps its previous value.
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    count_d = start_val;
                    state_d = (tgt_q == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (step) begin
                    // Exact compare on the stepped value: the counter stops
                    // on the end value and can never pass it.
                    count_d = count_nxt;
                    if (count_nxt == end_val)
                        state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // done still pulses this cycle; stop only cancels the rerun.
                state_d = (rep_q && !stop) ? ST_LOAD : ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count   = count_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign aborted = aborted_q;

endmodule
